// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_issue_ctrl
// Purpose  : Request sequencer in front of the SRT divider. Accepts one
//            divide request at a time, launches the divider with a single
//            start pulse, waits for completion under a watchdog, and returns
//            quotient/remainder with tag and status on a response handshake.
// Options  : DIV_SPECIAL_CASE_EN - when defined, divide-by-zero and the
//            most-negative / -1 overflow are answered directly, without
//            launching the divider.
// Revision : 1.0 - initial release
// ============================================================================
module div_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_status,
    output logic             busy
);

    localparam logic [1:0] c_ST_OK      = 2'b00;
    localparam logic [1:0] c_ST_DIVZERO = 2'b01;
    localparam logic [1:0] c_ST_OVF     = 2'b10;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b11;
    localparam logic [7:0] c_TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_ARM    = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [TAG_W-1:0] r_tag;
    logic [WIDTH-1:0] r_rsp_q;
    logic [WIDTH-1:0] r_rsp_r;
    logic [1:0]       r_status;
    logic [7:0]       r_wdog;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic             w_timeout;

`ifdef DIV_SPECIAL_CASE_EN
    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_div_zero = (req_divisor == '0);
    assign w_ovf      = (req_dividend == c_MOST_NEG) && (req_divisor == '1);
`else
    assign w_div_zero = 1'b0;
    assign w_ovf      = 1'b0;
`endif

    assign w_special = w_div_zero | w_ovf;
    assign w_accept  = req_valid && (r_state == S_IDLE);
    // Watchdog expiry only matters when the divider has not finished this cycle.
    assign w_timeout = (r_wdog == c_TIMEOUT_CNT);

    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign rsp_quotient  = r_rsp_q;
    assign rsp_remainder = r_rsp_r;
    assign rsp_tag       = r_tag;
    assign rsp_status    = r_status;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; divider ready wins over the watchdog.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        div_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_next = w_special ? S_RESP : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                div_start = 1'b1;
                w_next    = S_ARM;
            end
            S_ARM: begin
                // Divider ready is still high the cycle after start; skip it.
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (div_ready || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand/tag capture, watchdog, and response payload registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_tag      <= '0;
            r_rsp_q    <= '0;
            r_rsp_r    <= '0;
            r_status   <= c_ST_OK;
            r_wdog     <= '0;
        end else begin
            if (w_accept) begin
                r_dividend <= req_dividend;
                r_divisor  <= req_divisor;
                r_tag      <= req_tag;
                if (w_div_zero) begin
                    r_rsp_q  <= '1;
                    r_rsp_r  <= req_dividend;
                    r_status <= c_ST_DIVZERO;
                end else if (w_ovf) begin
                    r_rsp_q  <= req_dividend;
                    r_rsp_r  <= '0;
                    r_status <= c_ST_OVF;
                end
            end
            if (r_state == S_ARM) begin
                r_wdog <= '0;
            end
            if (r_state == S_WAIT) begin
                r_wdog <= r_wdog + 8'd1;
                if (div_ready) begin
                    r_rsp_q  <= div_quotient;
                    r_rsp_r  <= div_remainder;
                    r_status <= c_ST_OK;
                end else if (w_timeout) begin
                    r_rsp_q  <= '0;
                    r_rsp_r  <= '0;
                    r_status <= c_ST_TIMEOUT;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_issue_ctrl
// Purpose  : Directed self-checking bench for div_issue_ctrl with a
//            behavioural divider model of configurable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_dividend;
    logic [WIDTH-1:0] req_divisor;
    logic [TAG_W-1:0] req_tag;
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_quotient;
    logic [WIDTH-1:0] rsp_remainder;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_status;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    div_issue_ctrl #(
        .WIDTH   (WIDTH),
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_tag       (req_tag),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_ready     (div_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_tag       (rsp_tag),
        .rsp_status    (rsp_status),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Divider model: ready stays high the cycle after start, then drops
    // for m_lat cycles before presenting results (never, if m_hang).
    // ------------------------------------------------------------------
    logic        m_arm  = 1'b0;
    int          m_cnt  = 0;
    int          m_lat  = 12;
    bit          m_hang = 1'b0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;

    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {q, r};
    endfunction

    initial begin
        div_ready     = 1'b1;
        div_quotient  = '0;
        div_remainder = '0;
    end

    always @(posedge clk) begin
        if (div_start) begin
            m_arm <= 1'b1;
            m_cnt <= m_lat;
            m_a   <= div_dividend;
            m_b   <= div_divisor;
        end else if (m_arm) begin
            m_arm     <= 1'b0;
            div_ready <= 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1 && !m_hang) begin
                div_ready                     <= 1'b1;
                {div_quotient, div_remainder} <= model_div(m_a, m_b);
            end
        end
    end

    // Global safety net so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got running expected done");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside).
    // ------------------------------------------------------------------
    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        @(negedge clk);
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        req_tag      = t;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle after the accept edge.
    task automatic observe(input int limit, output int starts, output int first_start,
                           output int rsp_cyc);
        starts      = 0;
        first_start = 0;
        rsp_cyc     = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (div_start === 1'b1) begin
                starts++;
                if (first_start == 0) first_start = c;
            end
            if (rsp_valid === 1'b1) begin
                rsp_cyc = c;
                break;
            end
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [137:0] got;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        req_tag      = '0;
        rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        got = {req_ready, div_start, rsp_valid, busy, div_dividend, div_divisor,
               rsp_quotient, rsp_remainder, rsp_tag, rsp_status};
        n_checks++;
        if (got !== {4'b1000, 134'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", got, {4'b1000, 134'd0});
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b req_ready=%b expected busy=0 req_ready=1",
                     busy, req_ready);
        end
    endtask

    task automatic test_normal();
        int s, fs, rc;
        m_lat = 12;
        do_req(32'd100, 32'd7, 4'd3);
        observe(30, s, fs, rc);
        n_checks++;
        if (s !== 1 || fs !== 1 || rc !== 16) begin
            n_fail++;
            $display("FAIL normal_timing: got starts=%0d start_cyc=%0d rsp_cyc=%0d expected 1 1 16",
                     s, fs, rc);
        end
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, rsp_status} !== {32'd14, 32'd2, 4'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL normal_result: got q=%h r=%h tag=%h st=%b expected q=e r=2 tag=3 st=00",
                     rsp_quotient, rsp_remainder, rsp_tag, rsp_status);
        end
        n_checks++;
        if (div_dividend !== 32'd100 || div_divisor !== 32'd7) begin
            n_fail++;
            $display("FAIL normal_operands: got %h/%h expected 64/7", div_dividend, div_divisor);
        end
        release_rsp();
    endtask

    task automatic test_signed();
        int s, fs, rc;
        m_lat = 3;
        do_req(32'hFFFF_FF9C, 32'd7, 4'd5);
        observe(30, s, fs, rc);
        n_checks++;
        if (s !== 1 || rc !== 7) begin
            n_fail++;
            $display("FAIL signed_timing: got starts=%0d rsp_cyc=%0d expected 1 7", s, rc);
        end
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, rsp_status} !==
            {32'hFFFF_FFF2, 32'hFFFF_FFFE, 4'd5, 2'b00}) begin
            n_fail++;
            $display("FAIL signed_result: got q=%h r=%h tag=%h st=%b expected fffffff2 fffffffe 5 00",
                     rsp_quotient, rsp_remainder, rsp_tag, rsp_status);
        end
        release_rsp();
    endtask

    task automatic test_special();
        int s, fs, rc;
        m_lat = 2;
`ifdef DIV_SPECIAL_CASE_EN
        do_req(32'd123, 32'd0, 4'd9);
        observe(30, s, fs, rc);
        n_checks++;
        if (s !== 0 || rc !== 1) begin
            n_fail++;
            $display("FAIL divzero_timing: got starts=%0d rsp_cyc=%0d expected 0 1", s, rc);
        end
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, rsp_status} !==
            {32'hFFFF_FFFF, 32'd123, 4'd9, 2'b01}) begin
            n_fail++;
            $display("FAIL divzero_result: got q=%h r=%h tag=%h st=%b expected ffffffff 7b 9 01",
                     rsp_quotient, rsp_remainder, rsp_tag, rsp_status);
        end
        release_rsp();
        do_req(32'h8000_0000, 32'hFFFF_FFFF, 4'd10);
        observe(30, s, fs, rc);
        n_checks++;
        if (s !== 0 || rc !== 1) begin
            n_fail++;
            $display("FAIL ovf_timing: got starts=%0d rsp_cyc=%0d expected 0 1", s, rc);
        end
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, rsp_status} !==
            {32'h8000_0000, 32'd0, 4'd10, 2'b10}) begin
            n_fail++;
            $display("FAIL ovf_result: got q=%h r=%h tag=%h st=%b expected 80000000 0 a 10",
                     rsp_quotient, rsp_remainder, rsp_tag, rsp_status);
        end
        release_rsp();
`else
        do_req(32'h8000_0000, 32'hFFFF_FFFF, 4'd10);
        observe(30, s, fs, rc);
        n_checks++;
        if (s !== 1 || fs !== 1 || rc !== 6) begin
            n_fail++;
            $display("FAIL ovf_launch_timing: got starts=%0d start_cyc=%0d rsp_cyc=%0d expected 1 1 6",
                     s, fs, rc);
        end
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, rsp_status} !==
            {32'h8000_0000, 32'd0, 4'd10, 2'b00}) begin
            n_fail++;
            $display("FAIL ovf_launch_result: got q=%h r=%h tag=%h st=%b expected 80000000 0 a 00",
                     rsp_quotient, rsp_remainder, rsp_tag, rsp_status);
        end
        release_rsp();
        do_req(32'd123, 32'd0, 4'd9);
        observe(30, s, fs, rc);
        n_checks++;
        if (s !== 1 || rc !== 6 || rsp_status !== 2'b00 || rsp_remainder !== 32'd123) begin
            n_fail++;
            $display("FAIL divzero_launch: got starts=%0d rsp_cyc=%0d st=%b r=%h expected 1 6 00 7b",
                     s, rc, rsp_status, rsp_remainder);
        end
        release_rsp();
`endif
    endtask

    task automatic test_back_to_back();
        int s, fs, rc;
        logic [70:0] got;
        m_lat = 4;
        do_req(32'd50, 32'd6, 4'd7);
        observe(30, s, fs, rc);
        n_checks++;
        if (rc !== 8) begin
            n_fail++;
            $display("FAIL bp_first_rsp_cyc: got %0d expected 8", rc);
        end
        req_valid    = 1'b1;
        req_dividend = 32'd77;
        req_divisor  = 32'd5;
        req_tag      = 4'd2;
        for (int i = 0; i < 5; i++) begin
            got = {rsp_valid, req_ready, div_start, rsp_quotient, rsp_remainder, rsp_tag};
            n_checks++;
            if (got !== {3'b100, 32'd8, 32'd2, 4'd7} || rsp_status !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got %h st=%b expected %h st=00",
                         i, got, rsp_status, {3'b100, 32'd8, 32'd2, 4'd7});
            end
            @(negedge clk);
        end
        release_rsp();
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle_after_rsp: got req_ready=%b busy=%b expected 1 0", req_ready, busy);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        observe(30, s, fs, rc);
        n_checks++;
        if (s !== 1 || fs !== 1 || rc !== 8) begin
            n_fail++;
            $display("FAIL bp_second_timing: got starts=%0d start_cyc=%0d rsp_cyc=%0d expected 1 1 8",
                     s, fs, rc);
        end
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, rsp_status} !== {32'd15, 32'd2, 4'd2, 2'b00}) begin
            n_fail++;
            $display("FAIL bp_second_result: got q=%h r=%h tag=%h st=%b expected f 2 2 00",
                     rsp_quotient, rsp_remainder, rsp_tag, rsp_status);
        end
        release_rsp();
    endtask

    task automatic test_timeout();
        int s, fs, rc;
        m_lat  = 12;
        m_hang = 1'b1;
        do_req(32'd1000, 32'd3, 4'd4);
        observe(40, s, fs, rc);
        n_checks++;
        if (s !== 1 || rc !== 20) begin
            n_fail++;
            $display("FAIL timeout_timing: got starts=%0d rsp_cyc=%0d expected 1 20", s, rc);
        end
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, rsp_status} !== {32'd0, 32'd0, 4'd4, 2'b11}) begin
            n_fail++;
            $display("FAIL timeout_result: got q=%h r=%h tag=%h st=%b expected 0 0 4 11",
                     rsp_quotient, rsp_remainder, rsp_tag, rsp_status);
        end
        release_rsp();
        m_hang = 1'b0;
    endtask

    task automatic test_rsp_ready_idle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, busy, req_ready, div_start} !== 4'b0010) begin
                n_fail++;
                $display("FAIL idle_rsp_ready_%0d: got %b expected 0010",
                         i, {rsp_valid, busy, req_ready, div_start});
            end
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int s, fs, rc;
        logic [137:0] got;
        m_lat = 12;
        do_req(32'd200, 32'd9, 4'd6);
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_busy: got busy=%b rsp_valid=%b expected 1 0", busy, rsp_valid);
        end
        reset = 1'b0;
        #1;
        got = {req_ready, div_start, rsp_valid, busy, div_dividend, div_divisor,
               rsp_quotient, rsp_remainder, rsp_tag, rsp_status};
        n_checks++;
        if (got !== {4'b1000, 134'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h expected %h", got, {4'b1000, 134'd0});
        end
        @(negedge clk);
        reset = 1'b1;
        m_lat = 2;
        do_req(32'd200, 32'd9, 4'd6);
        observe(30, s, fs, rc);
        n_checks++;
        if (s !== 1 || fs !== 1 || rc !== 6) begin
            n_fail++;
            $display("FAIL post_reset_timing: got starts=%0d start_cyc=%0d rsp_cyc=%0d expected 1 1 6",
                     s, fs, rc);
        end
        n_checks++;
        if ({rsp_quotient, rsp_remainder, rsp_tag, rsp_status} !== {32'd22, 32'd2, 4'd6, 2'b00}) begin
            n_fail++;
            $display("FAIL post_reset_result: got q=%h r=%h tag=%h st=%b expected 16 2 6 00",
                     rsp_quotient, rsp_remainder, rsp_tag, rsp_status);
        end
        release_rsp();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_signed();
        test_special();
        test_back_to_back();
        test_timeout();
        test_rsp_ready_idle();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
